// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
//   Shared types and constants for the parametrised scratch RAM (param_sram)
//   and its zero-fill engine (sram_clear_fsm).
//   - clr_state_t : zero-fill engine state
//   - RDW_OLD/NEW : read-during-write selection for the RDW_MODE parameter
//   - LANE_W      : width of one byte-enable lane
//   - lanes()     : number of byte lanes in a data word
// ---------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;
    localparam int LANE_W  = 8;

    function automatic int lanes(input int data_w);
        return data_w / LANE_W;
    endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// ---------------------------------------------------------------------------
// sram_clear_fsm
//   Zero-fill engine. While in ST_CLEAR it walks fill_addr from 0 to DEPTH-1,
//   one word per clock, and asserts fill_we so the array owner writes zero.
//   busy is high for exactly DEPTH cycles per fill.
//
// Ports
//   Clk        in   rising-edge clock
//   Rst_n      in   synchronous active-low reset
//   clear      in   request a fill (honoured only in ST_IDLE)
//   busy       out  fill in progress
//   fill_we    out  write-zero strobe for the current fill_addr
//   fill_addr  out  word being cleared this cycle
//   state_dbg  out  current FSM state, for observation
// ---------------------------------------------------------------------------
module sram_clear_fsm
    import sram_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DEPTH      = 64,
    parameter int CLR_ON_RST = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              clear,
    output logic              busy,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output clr_state_t        state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam clr_state_t        RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    // Reset always rewinds the counter: with CLR_ON_RST=1 the fill restarts
    // from word 0, otherwise the engine simply aborts to idle.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        fill_we   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // clear is deliberately not looked at here: a running fill
                // is never restarted by another request.
                busy    = 1'b1;
                fill_we = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign fill_addr = cnt;
    assign state_dbg = state;

endmodule

// File: rtl/param_sram.sv
// ---------------------------------------------------------------------------
// param_sram
//   Parametrised single-clock scratch RAM: one write port and one read port
//   with independent addresses, byte-lane write enables, 1- or 2-cycle read
//   latency, selectable read-during-write result and a hardware zero-fill.
//
// Ports
//   Clk      in   rising-edge clock
//   Rst_n    in   synchronous active-low reset (array contents untouched)
//   CS       in   chip select, qualifies WR and RD
//   WR       in   write request
//   WrAddr   in   write address
//   Di       in   write data
//   BE       in   byte-lane enables, bit i covers Di[8i+7:8i]
//   RD       in   read request
//   RdAddr   in   read address
//   Do       out  read data, 0 whenever DoValid is low
//   DoValid  out  Do carries the result of an accepted read
//   Clear    in   one-cycle request to zero-fill the whole array
//   Busy     out  zero-fill running, user accesses are ignored
//
// Handshake: a write or read is accepted at a rising edge where CS and the
// request are high and Busy is low; there is no back-pressure otherwise.
// An accepted read produces exactly one DoValid pulse RD_LAT cycles later,
// and reads may be issued every cycle.
// ---------------------------------------------------------------------------
module param_sram
    import sram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int DEPTH      = 64,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 CS,
    input  logic                 WR,
    input  logic [ADDR_W-1:0]    WrAddr,
    input  logic [DATA_W-1:0]    Di,
    input  logic [DATA_W/8-1:0]  BE,
    input  logic                 RD,
    input  logic [ADDR_W-1:0]    RdAddr,
    output logic [DATA_W-1:0]    Do,
    output logic                 DoValid,
    input  logic                 Clear,
    output logic                 Busy
);

    localparam int                NLANE   = lanes(DATA_W);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

    // Elaboration-time parameter checks.
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("param_sram: RD_LAT must be 1 or 2");
    end
    if ((DATA_W % LANE_W) != 0) begin : g_bad_data_w
        $error("param_sram: DATA_W must be a multiple of 8");
    end
    if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("param_sram: DEPTH must not exceed 2**ADDR_W");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    clr_state_t        clr_state;

    logic              eng_idle;
    logic              wr_acc, rd_acc;
    logic              wr_in_range, rd_in_range;
    logic              same_addr_bypass;
    logic [DATA_W-1:0] old_word, merged_word, rd_word;

    sram_clear_fsm #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clear_fsm (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .clear     (Clear),
        .busy      (Busy),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .state_dbg (clr_state)
    );

    // User traffic is only taken while the fill engine is idle. A Clear on the
    // same edge as an access still lets that access through, since the engine
    // only leaves idle at that edge.
    assign eng_idle    = (clr_state == ST_IDLE);
    assign wr_acc      = CS & WR & eng_idle;
    assign rd_acc      = CS & RD & eng_idle;
    assign wr_in_range = ({1'b0, WrAddr} < DEPTH_V);
    assign rd_in_range = ({1'b0, RdAddr} < DEPTH_V);

    // Pre-write contents of the read word; out-of-range reads return zero.
    assign old_word = rd_in_range ? mem[RdAddr] : '0;

    // Word as it will look after this edge's write, used for the new-data
    // read-during-write option. Only meaningful when the addresses match.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NLANE; i++) begin
            if (BE[i]) begin
                merged_word[i*LANE_W +: LANE_W] = Di[i*LANE_W +: LANE_W];
            end
        end
    end

    assign same_addr_bypass = (RDW_MODE == RDW_NEW) && wr_acc && rd_in_range &&
                              (WrAddr == RdAddr);
    assign rd_word          = same_addr_bypass ? merged_word : old_word;

    // Array write port. Fill and user writes never overlap because user
    // writes are blocked while the engine runs. Nothing is written on a
    // reset edge, so an aborted fill leaves the current word intact.
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            if (fill_we) begin
                mem[fill_addr] <= '0;
            end else if (wr_acc && wr_in_range) begin
                for (int i = 0; i < NLANE; i++) begin
                    if (BE[i]) begin
                        mem[WrAddr][i*LANE_W +: LANE_W] <= Di[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    // Read pipeline. Data is captured as zero on idle cycles so Do is zero
    // whenever its valid bit is low, with no output-side masking needed.
    logic              v1;
    logic [DATA_W-1:0] d1;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc;
            d1 <= rd_acc ? rd_word : '0;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              v2;
        logic [DATA_W-1:0] d2;

        always_ff @(posedge Clk) begin
            if (!Rst_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                d2 <= d1;
            end
        end

        assign Do      = d2;
        assign DoValid = v2;
    end else begin : g_lat1
        assign Do      = d1;
        assign DoValid = v1;
    end

endmodule

// File: tb/tb_param_sram.sv
// ---------------------------------------------------------------------------
// tb_param_sram
//   Three param_sram instances:
//     u0 : defaults (8-bit, 64 words, RD_LAT=1, old-data RDW, clear on reset)
//     u1 : 32-bit, 48 words, RD_LAT=2, new-data RDW, clear on reset
//     u2 : 16-bit, 64 words, RD_LAT=1, new-data RDW, no clear on reset
//   Reads push their expected word and due cycle into per-instance queues;
//   negedge monitors pop and compare whenever DoValid is seen.
// ---------------------------------------------------------------------------
module tb_param_sram;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    int checks   = 0;
    int failures = 0;
    bit en       = 1'b0;
    int n0, n1;

    // ---------------- u0 ----------------
    logic       rst0_n, cs0, wr0, rd0, clr0, dv0, busy0;
    logic [5:0] wa0, ra0;
    logic [7:0] di0, do0;
    logic [0:0] be0;

    // ---------------- u1 ----------------
    logic        rst1_n, cs1, wr1, rd1, clr1, dv1, busy1;
    logic [5:0]  wa1, ra1;
    logic [31:0] di1, do1;
    logic [3:0]  be1;

    // ---------------- u2 ----------------
    logic        rst2_n, cs2, wr2, rd2, clr2, dv2, busy2;
    logic [5:0]  wa2, ra2;
    logic [15:0] di2, do2;
    logic [1:0]  be2;

    param_sram u0 (
        .Clk(Clk), .Rst_n(rst0_n), .CS(cs0), .WR(wr0), .WrAddr(wa0), .Di(di0),
        .BE(be0), .RD(rd0), .RdAddr(ra0), .Do(do0), .DoValid(dv0),
        .Clear(clr0), .Busy(busy0)
    );

    param_sram #(
        .DATA_W(32), .ADDR_W(6), .DEPTH(48), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1)
    ) u1 (
        .Clk(Clk), .Rst_n(rst1_n), .CS(cs1), .WR(wr1), .WrAddr(wa1), .Di(di1),
        .BE(be1), .RD(rd1), .RdAddr(ra1), .Do(do1), .DoValid(dv1),
        .Clear(clr1), .Busy(busy1)
    );

    param_sram #(
        .DATA_W(16), .ADDR_W(6), .DEPTH(64), .RD_LAT(1), .RDW_MODE(1), .CLR_ON_RST(0)
    ) u2 (
        .Clk(Clk), .Rst_n(rst2_n), .CS(cs2), .WR(wr2), .WrAddr(wa2), .Di(di2),
        .BE(be2), .RD(rd2), .RdAddr(ra2), .Do(do2), .DoValid(dv2),
        .Clear(clr2), .Busy(busy2)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q0[$], exp_q1[$], exp_q2[$];
    int          due_q0[$], due_q1[$], due_q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (en) begin
            if (dv0) begin
                check("u0_valid_expected", 32'(exp_q0.size() != 0), 32'd1);
                if (exp_q0.size() != 0) begin
                    check("u0_do", 32'(do0), exp_q0.pop_front());
                    check("u0_latency", cyc, due_q0.pop_front());
                end
            end else begin
                check("u0_do_idle_zero", 32'(do0), 32'd0);
            end
        end
    end

    always @(negedge Clk) begin
        if (en) begin
            if (dv1) begin
                check("u1_valid_expected", 32'(exp_q1.size() != 0), 32'd1);
                if (exp_q1.size() != 0) begin
                    check("u1_do", do1, exp_q1.pop_front());
                    check("u1_latency", cyc, due_q1.pop_front());
                end
            end else begin
                check("u1_do_idle_zero", do1, 32'd0);
            end
        end
    end

    always @(negedge Clk) begin
        if (en) begin
            if (dv2) begin
                check("u2_valid_expected", 32'(exp_q2.size() != 0), 32'd1);
                if (exp_q2.size() != 0) begin
                    check("u2_do", 32'(do2), exp_q2.pop_front());
                    check("u2_latency", cyc, due_q2.pop_front());
                end
            end else begin
                check("u2_do_idle_zero", 32'(do2), 32'd0);
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic op0(input logic wr, input logic [5:0] wa, input logic [7:0] di,
                       input logic be, input logic rd, input logic [5:0] ra,
                       input logic [7:0] exp);
        cs0 = 1'b1; wr0 = wr; wa0 = wa; di0 = di; be0 = be; rd0 = rd; ra0 = ra;
        if (rd) begin
            exp_q0.push_back(32'(exp));
            due_q0.push_back(cyc + 1);
        end
        @(negedge Clk);
        cs0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0;
    endtask

    task automatic op1(input logic wr, input logic [5:0] wa, input logic [31:0] di,
                       input logic [3:0] be, input logic rd, input logic [5:0] ra,
                       input logic [31:0] exp);
        cs1 = 1'b1; wr1 = wr; wa1 = wa; di1 = di; be1 = be; rd1 = rd; ra1 = ra;
        if (rd) begin
            exp_q1.push_back(exp);
            due_q1.push_back(cyc + 2);
        end
        @(negedge Clk);
        cs1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic op2(input logic wr, input logic [5:0] wa, input logic [15:0] di,
                       input logic [1:0] be, input logic rd, input logic [5:0] ra,
                       input logic [15:0] exp);
        cs2 = 1'b1; wr2 = wr; wa2 = wa; di2 = di; be2 = be; rd2 = rd; ra2 = ra;
        if (rd) begin
            exp_q2.push_back(32'(exp));
            due_q2.push_back(cyc + 1);
        end
        @(negedge Clk);
        cs2 = 1'b0; wr2 = 1'b0; rd2 = 1'b0;
    endtask

    // ---------------- u1 vector table ----------------
    typedef struct {
        logic        wr;
        logic [5:0]  wa;
        logic [31:0] di;
        logic [3:0]  be;
        logic        rd;
        logic [5:0]  ra;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        vecs[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 4'hF,    1'b0, 6'd0,  32'h0};
        vecs[1]  = '{1'b1, 6'd5,  32'h000000AA, 4'b0001, 1'b0, 6'd0,  32'h0};
        vecs[2]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd5,  32'hDEADBEAA};
        vecs[3]  = '{1'b1, 6'd50, 32'h12345678, 4'hF,    1'b0, 6'd0,  32'h0};
        vecs[4]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd50, 32'h0};
        vecs[5]  = '{1'b1, 6'd47, 32'hCAFEF00D, 4'hF,    1'b0, 6'd0,  32'h0};
        vecs[6]  = '{1'b1, 6'd7,  32'h11223344, 4'hF,    1'b0, 6'd0,  32'h0};
        vecs[7]  = '{1'b1, 6'd7,  32'h5566775A, 4'b1010, 1'b1, 6'd7,  32'h55227744};
        vecs[8]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd47, 32'hCAFEF00D};
        vecs[9]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd7,  32'h55227744};
        vecs[10] = '{1'b1, 6'd9,  32'h99999999, 4'hF,    1'b1, 6'd5,  32'hDEADBEAA};
        vecs[11] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd9,  32'h99999999};
        vecs[12] = '{1'b1, 6'd5,  32'hFFFFFFFF, 4'h0,    1'b0, 6'd0,  32'h0};
        vecs[13] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd5,  32'hDEADBEAA};
        vecs[14] = '{1'b1, 6'd1,  32'h00000011, 4'hF,    1'b0, 6'd0,  32'h0};
        vecs[15] = '{1'b1, 6'd2,  32'h00000022, 4'hF,    1'b0, 6'd0,  32'h0};
        vecs[16] = '{1'b1, 6'd3,  32'h00000033, 4'hF,    1'b0, 6'd0,  32'h0};
        vecs[17] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd1,  32'h00000011};
        vecs[18] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd2,  32'h00000022};
        vecs[19] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd3,  32'h00000033};
        vecs[20] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd0,  32'h0};
        vecs[21] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd48, 32'h0};

        rst0_n = 1'b0; cs0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
        wa0 = '0; ra0 = '0; di0 = '0; be0 = '0;
        rst1_n = 1'b0; cs1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0;
        wa1 = '0; ra1 = '0; di1 = '0; be1 = '0;
        rst2_n = 1'b0; cs2 = 1'b0; wr2 = 1'b0; rd2 = 1'b0; clr2 = 1'b0;
        wa2 = '0; ra2 = '0; di2 = '0; be2 = '0;

        // Reset state, sampled after the first reset edge.
        @(negedge Clk);
        en = 1'b1;
        check("u0_rst_busy", 32'(busy0), 32'd1);
        check("u0_rst_dovalid", 32'(dv0), 32'd0);
        check("u1_rst_busy", 32'(busy1), 32'd1);
        check("u1_rst_dovalid", 32'(dv1), 32'd0);
        check("u2_rst_busy", 32'(busy2), 32'd0);
        check("u2_rst_dovalid", 32'(dv2), 32'd0);
        repeat (2) @(negedge Clk);

        // Release reset; the reset-triggered fill runs DEPTH cycles.
        rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            @(negedge Clk);
        end
        check("u0_init_busy_cycles", n0, 64);
        check("u1_init_busy_cycles", n1, 48);
        check("u2_init_busy", 32'(busy2), 32'd0);

        // ---- u0: last address after fill, old-data read-during-write ----
        op0(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 6'd63, 8'h00);
        op0(1'b1, 6'd7, 8'hC3, 1'b1, 1'b0, 6'd0,  8'h00);
        op0(1'b1, 6'd7, 8'h5A, 1'b1, 1'b1, 6'd7,  8'hC3);
        op0(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 6'd7,  8'h5A);
        op0(1'b1, 6'd10, 8'hAB, 1'b1, 1'b0, 6'd0, 8'h00);
        op0(1'b1, 6'd11, 8'h00, 1'b0, 1'b1, 6'd10, 8'hAB);

        // ---- u0: Clear together with a write and a read ----
        cs0 = 1'b1; wr0 = 1'b1; wa0 = 6'd11; di0 = 8'h77; be0 = 1'b1;
        rd0 = 1'b1; ra0 = 6'd10; clr0 = 1'b1;
        exp_q0.push_back(32'h000000AB);
        due_q0.push_back(cyc + 1);
        @(negedge Clk);
        n0 = 0;
        while (busy0 && n0 < 200) begin
            cs0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
            if (n0 == 5) begin
                // Ignored while busy: neither the write nor the read may land.
                cs0 = 1'b1; wr0 = 1'b1; wa0 = 6'd12; di0 = 8'hEE; be0 = 1'b1;
                rd0 = 1'b1; ra0 = 6'd10;
            end
            if (n0 == 10) clr0 = 1'b1;
            n0++;
            @(negedge Clk);
        end
        cs0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
        check("u0_clear_busy_cycles", n0, 64);
        for (int a = 0; a < 64; a++) begin
            op0(1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 6'(a), 8'h00);
        end

        // ---- u1: table-driven vectors ----
        for (int i = 0; i < NVEC; i++) begin
            op1(vecs[i].wr, vecs[i].wa, vecs[i].di, vecs[i].be,
                vecs[i].rd, vecs[i].ra, vecs[i].exp);
        end
        repeat (4) @(negedge Clk);

        // ---- u1: reset in the middle of a fill, at counter 20 ----
        rst1_n = 1'b0;
        @(negedge Clk);
        rst1_n = 1'b1;
        check("u1_busy_after_rst", 32'(busy1), 32'd1);
        repeat (20) @(negedge Clk);
        rst1_n = 1'b0;
        @(negedge Clk);
        rst1_n = 1'b1;
        n1 = 0;
        while (busy1 && n1 < 200) begin
            n1++;
            @(negedge Clk);
        end
        check("u1_restart_busy_cycles", n1, 48);
        op1(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd7,  32'h0);
        op1(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd47, 32'h0);
        op1(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd9,  32'h0);

        // ---- u2: no fill on reset, reset aborts a fill ----
        for (int a = 0; a < 10; a++) begin
            op2(1'b1, 6'(a), 16'h1000 + 16'(a), 2'b11, 1'b0, 6'd0, 16'h0);
        end
        op2(1'b0, 6'd0, 16'h0,    2'b00, 1'b1, 6'd3, 16'h1003);
        op2(1'b1, 6'd3, 16'hABCD, 2'b10, 1'b1, 6'd3, 16'hAB03);
        op2(1'b0, 6'd0, 16'h0,    2'b00, 1'b1, 6'd3, 16'hAB03);
        repeat (2) @(negedge Clk);
        clr2 = 1'b1;
        @(negedge Clk);
        clr2 = 1'b0;
        check("u2_clear_busy", 32'(busy2), 32'd1);
        repeat (5) @(negedge Clk);
        rst2_n = 1'b0;
        @(negedge Clk);
        rst2_n = 1'b1;
        check("u2_abort_busy", 32'(busy2), 32'd0);
        for (int a = 0; a < 10; a++) begin
            op2(1'b0, 6'd0, 16'h0, 2'b00, 1'b1, 6'(a),
                (a < 5) ? 16'h0000 : 16'h1000 + 16'(a));
        end

        repeat (4) @(negedge Clk);
        check("u0_queue_drained", 32'(exp_q0.size()), 32'd0);
        check("u1_queue_drained", 32'(exp_q1.size()), 32'd0);
        check("u2_queue_drained", 32'(exp_q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_sram.md
Name: param_sram

Overview:
Parametrised successor of the team's 64x8 synchronous RAM.
- Separate write and read address ports.
- Byte-lane write enables.
- Configurable read latency (1 or 2 cycles) with a DoValid qualifier.
- Selectable read-during-write behaviour.
- Hardware zero-fill engine, run after reset or on request.
- Sits between bus/control logic and datapath as general scratch storage.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8
ADDR_W, 6, address width
DEPTH, 64, number of words; must satisfy DEPTH <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read/write in one cycle: 0 = old data, 1 = new data
CLR_ON_RST, 1, 1 = zero-fill starts automatically out of reset

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  synchronous active-low reset
CS  in  1  chip select; qualifies WR and RD
WR  in  1  write request
WrAddr  in  ADDR_W  write address
Di  in  DATA_W  write data
BE  in  DATA_W/8  byte-lane enables; bit i covers Di[8i+7:8i]
RD  in  1  read request
RdAddr  in  ADDR_W  read address
Do  out  DATA_W  read data; forced to 0 whenever DoValid=0
DoValid  out  1  Do carries the result of an accepted read
Clear  in  1  one-cycle request to zero-fill the whole array
Busy  out  1  zero-fill in progress; user accesses are ignored

Behaviour:
- Reset (Rst_n=0 at an edge): DoValid=0, Do=0, read pipeline flushed.
  - CLR_ON_RST=1: state CLEAR, fill counter 0, Busy=1.
  - CLR_ON_RST=0: state IDLE, Busy=0.
- Reset does not itself alter array contents.
- Write accept: CS & WR & !Busy at an edge. For each lane with BE[i]=1, mem[WrAddr] lane i <= Di lane i. Other lanes are unchanged.
- Read accept: CS & RD & !Busy at an edge t. DoValid=1 with Do=data after edge t+RD_LAT-1, i.e. RD_LAT cycles after the request. Back-to-back reads give one result per cycle.
- Read-during-write, same address, same edge:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (new lanes where BE=1, old lanes elsewhere).
- Different addresses in the same cycle are independent.
- Out-of-range address (>= DEPTH): write dropped; read accepted, returns 0 with DoValid=1.
- FSM states:
  - IDLE: Clear=1 at an edge -> CLEAR, counter=0, Busy=1 from the next cycle.
  - CLEAR: each edge writes mem[counter]=0 and increments the counter. At the edge where counter==DEPTH-1 -> IDLE, Busy=0. Busy is high for exactly DEPTH cycles.
  - Clear asserted while in CLEAR is ignored; the fill does not restart.
- Reads accepted before Busy rose complete normally. The zero-fill never disturbs in-flight read data.
- Reset mid-clear:
  - CLR_ON_RST=1: fill restarts from address 0.
  - CLR_ON_RST=0: FSM aborts to IDLE and words not yet cleared keep their contents.
- Clear and an accepted access at the same edge: the access completes, and the fill starts from the next edge.
- Illegal parameters (RD_LAT not 1 or 2, DATA_W%8!=0, DEPTH>2**ADDR_W) are flagged by an elaboration-time check.

Decomposition:
- Shared package sram_pkg holds:
  - state enum (ST_IDLE, ST_CLEAR)
  - RDW_OLD=0, RDW_NEW=1 constants
  - LANE_W=8
  - lanes(DATA_W) function
- One sub-module, sram_clear_fsm: owns state, fill counter and Busy, and outputs fill address plus write-zero strobe. The array, lane merge, bypass mux and read pipeline stay in param_sram.

Test Plan:
- Defaults, CLR_ON_RST=1: release Rst_n -> Busy=1 for 64 cycles, then 0; read addr 63 -> Do=8'h00, DoValid=1 one cycle later.
- DATA_W=32: write 0xDEADBEEF to addr 5 with BE=4'hF, then 0x000000AA with BE=4'b0001; read addr 5 -> 0xDEADBEAA.
- RD_LAT=2: read addrs 1,2,3 back-to-back holding 0x11,0x22,0x33 -> DoValid high cycles t+2..t+4 with 0x11,0x22,0x33; Do=0 when DoValid=0.
- Same-cycle write 0x5A and read of addr 7 holding 0xC3 -> RDW_MODE=0 returns 0xC3; RDW_MODE=1 returns 0x5A.
- Pulse Clear, then issue write and read during Busy -> both ignored, DoValid stays 0. After fill, every address reads 0.
- DEPTH=48, ADDR_W=6: write addr 50 is dropped; read addr 50 -> 0 with DoValid=1. Apply Rst_n mid-clear at counter=20 -> fill restarts and Busy lasts 48 more cycles.
